sifive_scope_hart_0_dcache_d_capture: RTL and testbench

//  Passive trace-capture stage downstream of the hart-0 dcache TileLink D-channel scope tap.

---
 rtl/sifive_scope_dcache_d_pkg.sv | 45 ++++
 rtl/sifive_scope_hart_0_dcache_d_capture_if.sv | 32 +++
 rtl/sifive_scope_trace_fifo.sv | 40 ++++
 rtl/sifive_scope_hart_0_dcache_d_capture.sv | 113 +++++++++++
 tb/tb_sifive_scope_hart_0_dcache_d_capture.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/sifive_scope_dcache_d_pkg.sv
// Shared types and helpers for the hart-0 dcache D-channel trace capture.
package sifive_scope_dcache_d_pkg;

  localparam int unsigned TS_W  = 16;
  localparam int unsigned CNT_W = 16;

  // TileLink D-channel opcodes
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] OP_HINT_ACK        = 3'd2;
  localparam logic [2:0] OP_GRANT           = 3'd4;
  localparam logic [2:0] OP_GRANT_DATA      = 3'd5;
  localparam logic [2:0] OP_RELEASE_ACK     = 3'd6;

  typedef struct packed {
    logic            marker;
    logic [TS_W-1:0] ts;
    logic            first;
    logic            last;
    logic [2:0]      opcode;
    logic [1:0]      param;
    logic [3:0]      size;
    logic [2:0]      source;
    logic            sink;
    logic            denied;
    logic            corrupt;
    logic [31:0]     data;
  } rec_t;

  localparam int unsigned REC_W = $bits(rec_t);

  // Beats in a D message; data-bearing messages wider than the 4-byte bus span several beats.
  function automatic logic [4:0] beats(input logic [2:0] opcode, input logic [3:0] size);
    if ((opcode == OP_ACCESS_ACK_DATA || opcode == OP_GRANT_DATA) && size > 4'd2) begin
      if (size >= 4'd6) return 5'd16;
      return 5'd1 << (size - 4'd2);
    end
    return 5'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sifive_scope_hart_0_dcache_d_capture_if.sv
// Observed D channel plus the trace output handshake.
interface sifive_scope_hart_0_dcache_d_capture_if;
  import sifive_scope_dcache_d_pkg::*;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [2:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;
  logic        trace_valid;
  logic        trace_ready;
  rec_t        trace_bits;

  // Drives the D tap and consumes trace records
  modport master (
    output d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt,
           d_data, trace_ready,
    input  trace_valid, trace_bits
  );

  // The capture stage: observes D, produces trace records
  modport slave (
    input  d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt,
           d_data, trace_ready,
    output trace_valid, trace_bits
  );
endinterface

// File: rtl/sifive_scope_trace_fifo.sv
// Small synchronous FIFO; pointers carry a wrap bit to tell full from empty.
module sifive_scope_trace_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage; contents are masked by empty at the top, so no reset needed
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sifive_scope_hart_0_dcache_d_capture.sv
// Passive D-channel trace capture: tags fired beats, filters, buffers, and accounts for drops.
module sifive_scope_hart_0_dcache_d_capture
  import sifive_scope_dcache_d_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic                                 clear,
  input  logic [7:0]                           opcode_mask,
  sifive_scope_hart_0_dcache_d_capture_if.slave tap,
  output logic                                 overflow,
  output logic [CNT_W-1:0]                     drop_count
);

  logic [TS_W-1:0]  ts_q;
  logic [3:0]       beat_q, beat_d;
  logic [CNT_W-1:0] episode_q, episode_d, drop_q, drop_d;
  logic             overflow_q, overflow_d, pend_q, pend_d;

  logic       fire, cap, pop, space, full, empty, push, first, last, drop;
  logic [4:0] n_beats;
  rec_t       wrec;
  logic [REC_W-1:0] head;

  assign fire    = tap.d_valid & tap.d_ready;
  assign n_beats = beats(tap.d_opcode, tap.d_size);
  assign first   = (beat_q == 4'd0);
  assign last    = ({1'b0, beat_q} == n_beats - 5'd1);
  assign cap     = fire & enable & opcode_mask[tap.d_opcode];
  assign pop     = tap.trace_valid & tap.trace_ready;
  assign space   = !full | pop;
  // Any capture that cannot go straight in is lost, including every one behind a pending marker
  assign drop    = cap & ~(space & ~pend_q);
  assign beat_d  = last ? 4'd0 : beat_q + 4'd1;

  // Write mux and drop accounting; clear applies before a same-cycle drop
  always_comb begin
    push       = 1'b0;
    wrec       = '0;
    episode_d  = clear ? '0 : episode_q;
    drop_d     = clear ? '0 : drop_q;
    overflow_d = clear ? 1'b0 : overflow_q;
    pend_d     = pend_q;
    if (drop) begin
      episode_d  = sat_inc(episode_d);
      drop_d     = sat_inc(drop_d);
      overflow_d = 1'b1;
      pend_d     = 1'b1;
    end
    if (pend_q && space) begin
      push                   = 1'b1;
      wrec.marker            = 1'b1;
      wrec.ts                = ts_q;
      wrec.data[CNT_W-1:0]   = episode_d;
      episode_d              = '0;
      pend_d                 = 1'b0;
    end else if (cap && space) begin
      push         = 1'b1;
      wrec.ts      = ts_q;
      wrec.first   = first;
      wrec.last    = last;
      wrec.opcode  = tap.d_opcode;
      wrec.param   = tap.d_param;
      wrec.size    = tap.d_size;
      wrec.source  = tap.d_source;
      wrec.sink    = tap.d_sink;
      wrec.denied  = tap.d_denied;
      wrec.corrupt = tap.d_corrupt;
      wrec.data    = tap.d_data;
    end
  end

  // Timestamp, beat tracking and drop state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q       <= '0;
      beat_q     <= '0;
      episode_q  <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      ts_q       <= ts_q + 1'b1;
      if (fire) beat_q <= beat_d;
      episode_q  <= episode_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      pend_q     <= pend_d;
    end
  end

  sifive_scope_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wrec),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign tap.trace_valid = !empty;
  assign tap.trace_bits  = empty ? '0 : rec_t'(head);
  assign overflow        = overflow_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_sifive_scope_hart_0_dcache_d_capture.sv
// Directed bench for the D-channel trace capture stage.
module tb_sifive_scope_hart_0_dcache_d_capture;
  import sifive_scope_dcache_d_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic [7:0]  opcode_mask;
  logic        overflow;
  logic [15:0] drop_count;
  logic [15:0] tb_ts;
  int          n_pass = 0;
  int          n_total = 0;
  rec_t        exp_q[$];
  rec_t        head_r;
  logic [15:0] ta, mts;

  sifive_scope_hart_0_dcache_d_capture_if tap ();

  sifive_scope_hart_0_dcache_d_capture #(.DEPTH(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .opcode_mask (opcode_mask),
    .tap         (tap),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  // Reference cycle counter: the timestamp a record fired in this cycle must carry
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 16'd1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic rec_t mk(input logic m, input logic [15:0] ts, input logic f, input logic l,
                              input logic [2:0] op, input logic [3:0] sz, input logic [31:0] data);
    rec_t r;
    r = '0;
    r.marker = m;
    r.ts     = ts;
    r.first  = f;
    r.last   = l;
    r.opcode = op;
    r.data   = data;
    if (!m) begin
      r.param   = 2'd1;
      r.size    = sz;
      r.source  = 3'd5;
      r.sink    = 1'b1;
      r.denied  = 1'b0;
      r.corrupt = data[0];
    end
    return r;
  endfunction

  // One fired beat; f/l are the hand-derived first/last flags, cap says it should be recorded
  task automatic beat(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] data,
                      input logic f, input logic l, input logic cap);
    tap.d_valid   = 1'b1;
    tap.d_ready   = 1'b1;
    tap.d_opcode  = op;
    tap.d_param   = 2'd1;
    tap.d_size    = sz;
    tap.d_source  = 3'd5;
    tap.d_sink    = 1'b1;
    tap.d_denied  = 1'b0;
    tap.d_corrupt = data[0];
    tap.d_data    = data;
    if (cap) exp_q.push_back(mk(1'b0, tb_ts, f, l, op, sz, data));
    tick();
    tap.d_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    chk({tag, "_valid"}, tap.trace_valid, 1'b1);
    chk({tag, "_rec"}, tap.trace_bits, exp_q.pop_front());
    tap.trace_ready = 1'b1;
    tick();
    tap.trace_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_chk(tag);
    chk({tag, "_empty"}, tap.trace_valid, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b1;
    clear = 1'b0;
    opcode_mask = 8'hFF;
    tap.d_valid = 1'b0;
    tap.d_ready = 1'b0;
    tap.d_opcode = '0;
    tap.d_param = '0;
    tap.d_size = '0;
    tap.d_source = '0;
    tap.d_sink = 1'b0;
    tap.d_denied = 1'b0;
    tap.d_corrupt = 1'b0;
    tap.d_data = '0;
    tap.trace_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", tap.trace_valid, 1'b0);
    chk("rst_bits", tap.trace_bits, 66'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drops", drop_count, 16'd0);
    reset_n = 1'b1;
    tick();

    // 1: single-beat AccessAck, one-cycle latency
    chk("t1_pre_valid", tap.trace_valid, 1'b0);
    beat(3'd0, 4'd2, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1);
    drain("t1");

    // 2: 4-beat AccessAckData, enable dropped after beat 1
    beat(3'd1, 4'd4, 32'h2000_0000, 1'b1, 1'b0, 1'b1);
    beat(3'd1, 4'd4, 32'h2000_0001, 1'b0, 1'b0, 1'b1);
    enable = 1'b0;
    beat(3'd1, 4'd4, 32'h2000_0002, 1'b0, 1'b0, 1'b0);
    beat(3'd1, 4'd4, 32'h2000_0003, 1'b0, 1'b1, 1'b0);
    enable = 1'b1;
    drain("t2a");
    beat(3'd1, 4'd3, 32'h2100_0000, 1'b1, 1'b0, 1'b1);
    beat(3'd1, 4'd3, 32'h2100_0001, 1'b0, 1'b1, 1'b1);
    drain("t2b");

    // 3: DEPTH+3 captures with the sink stalled
    for (int i = 0; i < 7; i++) beat(3'd0, 4'd2, 32'h300 + i, 1'b1, 1'b1, i < 4);
    chk("t3_drops", drop_count, 16'd3);
    chk("t3_overflow", overflow, 1'b1);
    mts = tb_ts;
    pop_chk("t3_pop0");
    exp_q.push_back(mk(1'b1, mts, 1'b0, 1'b0, 3'd0, 4'd0, 32'd3));
    pop_chk("t3_pop1");
    beat(3'd0, 4'd2, 32'h0000_0355, 1'b1, 1'b1, 1'b1);
    drain("t3");

    // 4: full FIFO, pop and capture in the same cycle
    for (int i = 0; i < 4; i++) beat(3'd0, 4'd2, 32'h400 + i, 1'b1, 1'b1, 1'b1);
    chk("t4_head", tap.trace_bits, exp_q.pop_front());
    tap.trace_ready = 1'b1;
    beat(3'd0, 4'd2, 32'h0000_0444, 1'b1, 1'b1, 1'b1);
    tap.trace_ready = 1'b0;
    chk("t4_drops", drop_count, 16'd3);
    drain("t4");

    // 5: clear, then mask filtering and timestamp gap
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clr_drops", drop_count, 16'd0);
    chk("t5_clr_overflow", overflow, 1'b0);
    opcode_mask = 8'h02;
    ta = tb_ts;
    beat(3'd0, 4'd2, 32'h5000_0000, 1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    beat(3'd1, 4'd2, 32'h5000_0001, 1'b1, 1'b1, 1'b1);
    head_r = tap.trace_bits;
    chk("t5_ts_gap", head_r.ts - ta, 16'd6);
    drain("t5");
    opcode_mask = 8'hFF;

    // 6: clear coinciding with a drop, then reset mid-burst
    for (int i = 0; i < 6; i++) beat(3'd0, 4'd2, 32'h600 + i, 1'b1, 1'b1, i < 4);
    chk("t6_drops2", drop_count, 16'd2);
    clear = 1'b1;
    beat(3'd0, 4'd2, 32'h0000_0666, 1'b1, 1'b1, 1'b0);
    clear = 1'b0;
    chk("t6_clr_drop_cnt", drop_count, 16'd1);
    chk("t6_clr_drop_ovf", overflow, 1'b1);
    beat(3'd1, 4'd4, 32'h6100_0000, 1'b1, 1'b0, 1'b0);
    beat(3'd1, 4'd4, 32'h6100_0001, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", tap.trace_valid, 1'b0);
    chk("t6_rst_bits", tap.trace_bits, 66'd0);
    chk("t6_rst_overflow", overflow, 1'b0);
    chk("t6_rst_drops", drop_count, 16'd0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    beat(3'd1, 4'd4, 32'h6200_0000, 1'b1, 1'b0, 1'b1);
    drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
